// File: rtl/cond_compare_seq.sv
// ============================================================================
// cond_compare_seq : chunk-serial, MSB-first operand comparator producing the
//                    set-conditional / zero-test flag COMP_OUT.
// Optional macro   : COND_COMPARE_EARLY_EXIT_EN (finish on first differing chunk)
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_compare_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic             COMP_OUT
);

  localparam int c_N  = WIDTH / CHUNK;
  localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;

  localparam logic [2:0] c_OP_SEQ = 3'b000;
  localparam logic [2:0] c_OP_SNE = 3'b001;
  localparam logic [2:0] c_OP_SLT = 3'b010;
  localparam logic [2:0] c_OP_SGT = 3'b011;
  localparam logic [2:0] c_OP_SLE = 3'b100;
  localparam logic [2:0] c_OP_SGE = 3'b101;
  localparam logic [2:0] c_OP_EQZ = 3'b110;
  localparam logic [2:0] c_OP_NEZ = 3'b111;

  localparam logic [WIDTH-1:0] c_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_width_check
      $error("cond_compare_seq: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RES  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_eq;
  logic             r_lt;
  logic [c_CW-1:0]  r_cnt;

  logic             w_signed;
  logic             w_zero_test;
  logic [WIDTH-1:0] w_a_in;
  logic [WIDTH-1:0] w_b_in;
  logic [CHUNK-1:0] w_chunk_a;
  logic [CHUNK-1:0] w_chunk_b;
  logic             w_eq_nxt;
  logic             w_lt_nxt;
  logic             w_last;
  logic             w_finish;
  logic             w_result;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_signed    = (OP == c_OP_SLT) || (OP == c_OP_SGT) ||
                       (OP == c_OP_SLE) || (OP == c_OP_SGE);
  assign w_zero_test = (OP == c_OP_EQZ) || (OP == c_OP_NEZ);
  assign w_a_in      = w_signed ? (A ^ c_MSB) : A;
  assign w_b_in      = w_zero_test ? '0 : (w_signed ? (B ^ c_MSB) : B);

  // Operands shift left each CMP cycle, so the current chunk is always on top.
  assign w_chunk_a = r_a[WIDTH-1 -: CHUNK];
  assign w_chunk_b = r_b[WIDTH-1 -: CHUNK];

  always_comb begin
    w_eq_nxt = r_eq;
    w_lt_nxt = r_lt;
    if (r_eq && (w_chunk_a != w_chunk_b)) begin
      w_eq_nxt = 1'b0;
      w_lt_nxt = (w_chunk_a < w_chunk_b);
    end
  end

  assign w_last = (r_cnt == c_CW'(c_N - 1));

`ifdef COND_COMPARE_EARLY_EXIT_EN
  assign w_finish = w_last || !w_eq_nxt;
`else
  assign w_finish = w_last;
`endif

  always_comb begin
    w_result = 1'b0;
    case (r_op)
      c_OP_SEQ, c_OP_EQZ: w_result = w_eq_nxt;
      c_OP_SNE, c_OP_NEZ: w_result = !w_eq_nxt;
      c_OP_SLT:           w_result = w_lt_nxt;
      c_OP_SGT:           w_result = !w_eq_nxt && !w_lt_nxt;
      c_OP_SLE:           w_result = w_eq_nxt || w_lt_nxt;
      c_OP_SGE:           w_result = !w_lt_nxt;
      default:            w_result = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
      r_cnt    <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      COMP_OUT <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            r_a     <= w_a_in;
            r_b     <= w_b_in;
            r_op    <= OP;
            r_eq    <= 1'b1;
            r_lt    <= 1'b0;
            r_cnt   <= '0;
            BUSY    <= 1'b1;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          r_eq <= w_eq_nxt;
          r_lt <= w_lt_nxt;
          r_a  <= r_a << CHUNK;
          r_b  <= r_b << CHUNK;
          // Result is registered on the way into RES so DONE and COMP_OUT align.
          if (w_finish) begin
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            COMP_OUT <= w_result;
            r_state  <= S_RES;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        S_RES: begin
          DONE    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cond_compare_seq.sv
// ============================================================================
// tb_cond_compare_seq : scoreboard bench for cond_compare_seq (directed vectors)
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_compare_seq;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [2:0]  OP;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        DONE;
  logic        COMP_OUT;

  cond_compare_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .OP       (OP),
    .A        (A),
    .B        (B),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .COMP_OUT (COMP_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic  exp;
    int    due;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!RESET && DONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_comp_out"}, {31'd0, COMP_OUT}, {31'd0, e.exp});
        chk({e.name, "_done_cycle"}, cyc, e.due);
      end
    end
  end

  // k = 1-based index of the first differing chunk (4 when the operands match).
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic exp, input int k, input bit spam);
    int lat;
    int t0;
`ifdef COND_COMPARE_EARLY_EXIT_EN
    lat = k + 1;
`else
    lat = 5;
`endif
    @(negedge CLK);
    OP = op; A = a; B = b; START = 1'b1;
    t0 = cyc;
    sb.push_back('{exp, t0 + lat, name});
    for (int p = 1; p <= lat; p++) begin
      @(negedge CLK);
      if (spam) begin
        START = 1'b1;
        OP    = 3'b000;
        A     = $urandom;
        B     = $urandom;
      end else begin
        START = 1'b0;
      end
      if (p < lat) chk({name, "_busy_cmp"}, {31'd0, BUSY}, 32'd1);
      else         chk({name, "_busy_res"}, {31'd0, BUSY}, 32'd0);
    end
    @(negedge CLK);
    START = 1'b0;
    chk({name, "_busy_idle"}, {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; START = 1'b0; OP = 3'b000; A = '0; B = '0;
    repeat (3) @(negedge CLK);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_done", {31'd0, DONE}, 32'd0);
    chk("reset_comp", {31'd0, COMP_OUT}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    run_op("slt_neg1_lt_1",   3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, 1'b0);
    run_op("sge_min_vs_max",  3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1, 1'b0);
    run_op("sgt_max_vs_min",  3'b011, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1, 1'b0);
    run_op("seq_equal",       3'b000, 32'h1234_5678, 32'h1234_5678, 1'b1, 4, 1'b0);
    run_op("sne_equal",       3'b001, 32'h1234_5678, 32'h1234_5678, 1'b0, 4, 1'b0);
    run_op("eqz_zero",        3'b110, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 4, 1'b0);
    run_op("nez_0x100",       3'b111, 32'h0000_0100, 32'h0000_0100, 1'b1, 3, 1'b0);
    run_op("slt_1_vs_neg1",   3'b010, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
    run_op("slt_last_chunk",  3'b010, 32'h0000_0005, 32'h0000_0003, 1'b0, 4, 1'b0);
    run_op("sle_early",       3'b100, 32'h0100_0000, 32'h0200_0000, 1'b1, 1, 1'b0);
    run_op("sle_equal",       3'b100, 32'h0100_0000, 32'h0100_0000, 1'b1, 4, 1'b0);
    run_op("sgt_equal",       3'b011, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 4, 1'b0);
    run_op("start_spam_slt",  3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, 1'b1);

    // Abort an SLT mid-compare; COMP_OUT is 1 beforehand so the clear is visible.
    @(negedge CLK);
    OP = 3'b010; A = 32'hFFFF_FFFF; B = 32'h0000_0001; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("async_rst_done", {31'd0, DONE}, 32'd0);
    chk("async_rst_comp", {31'd0, COMP_OUT}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (8) @(negedge CLK);
    chk("post_rst_comp_hold", {31'd0, COMP_OUT}, 32'd0);
    run_op("after_reset_sgt", 3'b011, 32'h0000_0010, 32'h0000_000F, 1'b1, 4, 1'b0);

    repeat (4) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cond_compare_seq.md
Name: cond_compare_seq

Overview:
- Multi-cycle comparator that produces the 1-bit COMP_OUT condition consumed by the execute stage for set-conditional (SEQ/SNE/SLT/SGT/SLE/SGE) and zero-test (BEQZ/BNEZ) instructions.
- It reduces two 32-bit operands to one flag, CHUNK bits per cycle, MSB-first, so the TinyML-extended DLX saves comparator area.
- START/BUSY/DONE handshake with the control FSM; the result is held on COMP_OUT until the next operation.

Parameters:
- WIDTH, 32, operand width; must be an integer multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; N = WIDTH/CHUNK compare cycles (default 4).

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- OP  input  3  000 SEQ, 001 SNE, 010 SLT, 011 SGT, 100 SLE, 101 SGE, 110 EQZ, 111 NEZ.
- A  input  WIDTH  operand 1 (register source 1).
- B  input  WIDTH  operand 2; ignored for EQZ/NEZ.
- BUSY  output  1  high while comparing.
- DONE  output  1  one-cycle pulse when COMP_OUT is updated.
- COMP_OUT  output  1  registered condition result.

Behaviour:
- Reset: state IDLE, BUSY=0, DONE=0, COMP_OUT=0, chunk counter=0, internal flags cleared.
- Reset is asynchronous and may occur at any time. Mid-operation it aborts to IDLE and no DONE is produced.
- States: IDLE -> CMP -> RES -> IDLE. All outputs are registered.
- IDLE:
  - START=1 latches A, OP, and B into operand registers. For EQZ/NEZ, B is latched as 0.
  - Signed ops (SLT/SGT/SLE/SGE) invert the MSB of both latched operands, so an unsigned chunk compare yields the signed order.
  - Clears eq=1, lt=0, counter=0. Next state CMP.
- CMP, one chunk per cycle from the MSB (chunk index = counter):
  - If eq=1 and chunk_A != chunk_B: eq<=0, and lt<=(chunk_A < chunk_B) unsigned.
  - Once eq=0, later chunks are ignored.
  - After chunk N-1: next state RES. Otherwise counter+1.
- RES (one cycle):
  - COMP_OUT per OP: SEQ/EQZ=eq; SNE/NEZ=!eq; SLT=lt; SGT=!eq&!lt; SLE=eq|lt; SGE=!lt.
  - DONE=1 for this cycle only. Next state IDLE.
- BUSY=1 exactly in CMP cycles and 0 in IDLE/RES.
- Timing (default, START accepted at cycle 0):
  - BUSY high cycles 1..N.
  - DONE and the new COMP_OUT visible at cycle N+1.
  - Earliest next START accepted at cycle N+2.
- START while BUSY or in RES is ignored; no queueing.
- A/B/OP changes after acceptance have no effect (operands are latched).
- COMP_OUT holds its last value until the next RES cycle. It never toggles during CMP.
- WIDTH not a multiple of CHUNK is unsupported (elaboration check recommended).

Optional Feature:
- Macro COND_COMPARE_EARLY_EXIT_EN.
- Defined: CMP goes to RES in the same cycle eq first clears. Latency from START becomes k+1, where k = 1-based index of the first differing chunk from the MSB. Equal operands still take N+1.
- Undefined: fixed latency N+1 for every operation, so the control FSM can use a constant stall count.

Test Plan:
- SLT, A=0xFFFFFFFF (-1), B=0x00000001, START at cycle 0 -> BUSY cycles 1-4, DONE pulse at cycle 5, COMP_OUT=1.
- SGE, A=0x80000000, B=0x7FFFFFFF -> COMP_OUT=0. SGT with swapped operands -> COMP_OUT=1.
- SEQ, A=B=0x12345678 -> COMP_OUT=1. SNE same operands -> 0. EQZ A=0, B=0xDEADBEEF -> 1. NEZ A=0x00000100 -> 1.
- START re-asserted every cycle during BUSY with different A/B -> ignored, single DONE, result from the first operands only.
- RESET pulsed at cycle 2 of an SLT -> BUSY=0, DONE=0, COMP_OUT=0 immediately (asynchronous). No DONE afterwards. A new START after release completes normally.
- With COND_COMPARE_EARLY_EXIT_EN, SLE A=0x01000000, B=0x02000000 -> DONE at cycle 2, COMP_OUT=1. A=B -> DONE at cycle 5.
